rj_loader_l: RTL and testbench

//   Left-channel rj coefficient loader. Sits directly upstream of the left rj coefficient memory.

---
 rtl/rj_loader_l.sv | 203 ++++++++++++++++++++
 tb/tb_rj_loader_l.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rj_loader_l.sv
// -----------------------------------------------------------------------------
// rj_loader_l
//   Left-channel rj coefficient loader. Deserialises DEPTH MSB-first words of
//   WORD_W bits from InputL and writes each word into the left rj coefficient
//   memory through a one-cycle write strobe. The memory samples row/Input on
//   the rising edge of that strobe.
//
// Ports
//   Sclk       in   system/serial clock, all logic on its rising edge
//   Reset_n    in   asynchronous active-low reset
//   Start      in   pulse: begin a load sequence (only honoured in IDLE/DONE)
//   Clear      in   pulse: abort and request a memory clear (beats Start/Frame)
//   Frame      in   word-start marker, high while the word MSB is on InputL
//   InputL     in   serial data, MSB first
//   rj_status  out  memory write strobe, high for exactly one cycle per word
//   row        out  memory row of the most recently completed word
//   Input      out  most recently completed word
//   clear_mem  out  memory clear request, held until the first strobe after
//                   Clear has fallen
//   rj_busy    out  high from an accepted Start until DONE
//   rj_done    out  high in DONE until the next Start/Clear
//   frame_err  out  sticky: Frame seen mid-word, cleared by Start/Clear
// -----------------------------------------------------------------------------
module rj_loader_l #(
    parameter int WORD_W = 16,
    parameter int DEPTH  = 16,
    parameter int ROW_W  = 4
) (
    input  logic              Sclk,
    input  logic              Reset_n,
    input  logic              Start,
    input  logic              Clear,
    input  logic              Frame,
    input  logic              InputL,
    output logic              rj_status,
    output logic [ROW_W-1:0]  row,
    output logic [WORD_W-1:0] Input,
    output logic              clear_mem,
    output logic              rj_busy,
    output logic              rj_done,
    output logic              frame_err
);

    localparam int BC_W = $clog2(WORD_W + 1);
    localparam logic [BC_W-1:0]  BC_ONE   = BC_W'(1);
    localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(WORD_W - 1);
    localparam logic [BC_W-1:0]  BC_FULL  = BC_W'(WORD_W);
    localparam logic [ROW_W-1:0] CNT_LAST = ROW_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FRAME,
        SHIFT,
        STROBE,
        DONE
    } state_t;

    state_t              state_q,  state_d;
    // Only WORD_W-1 bits are held: the final bit is merged straight into the
    // output word in the cycle it arrives.
    logic [WORD_W-2:0]   shift_q,  shift_d;
    logic [BC_W-1:0]     bitcnt_q, bitcnt_d;
    logic [ROW_W-1:0]    cnt_q,    cnt_d;
    logic [ROW_W-1:0]    row_q,    row_d;
    logic [WORD_W-1:0]   word_q,   word_d;
    logic                strobe_q, strobe_d;
    logic                clr_q,    clr_d;
    logic                busy_q,   busy_d;
    logic                done_q,   done_d;
    logic                ferr_q,   ferr_d;

    always_ff @(posedge Sclk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            bitcnt_q <= '0;
            cnt_q    <= '0;
            row_q    <= '0;
            word_q   <= '0;
            strobe_q <= 1'b0;
            clr_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            bitcnt_q <= bitcnt_d;
            cnt_q    <= cnt_d;
            row_q    <= row_d;
            word_q   <= word_d;
            strobe_q <= strobe_d;
            clr_q    <= clr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ferr_q   <= ferr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bitcnt_d = bitcnt_q;
        cnt_d    = cnt_q;
        row_d    = row_q;
        word_d   = word_q;
        clr_d    = clr_q;
        busy_d   = busy_q;
        done_d   = done_q;
        ferr_d   = ferr_q;

        if (Clear) begin
            state_d  = IDLE;
            bitcnt_d = '0;
            cnt_d    = '0;
            busy_d   = 1'b0;
            done_d   = 1'b0;
            ferr_d   = 1'b0;
            clr_d    = 1'b1;
        end else begin
            // The clear request retires as the first strobe after Clear ends,
            // so the memory still sees clear=1 on that strobe's rising edge.
            if (state_q == STROBE) begin
                clr_d = 1'b0;
            end

            case (state_q)
                IDLE, DONE: begin
                    if (Start) begin
                        state_d  = WAIT_FRAME;
                        bitcnt_d = '0;
                        cnt_d    = '0;
                        busy_d   = 1'b1;
                        done_d   = 1'b0;
                        ferr_d   = 1'b0;
                    end
                end

                WAIT_FRAME: begin
                    if (Frame) begin
                        shift_d  = (WORD_W-1)'(InputL);
                        bitcnt_d = BC_ONE;
                        state_d  = SHIFT;
                    end
                end

                SHIFT: begin
                    if (bitcnt_q == BC_FULL) begin
                        // Word already presented on Input/row for one cycle.
                        state_d = STROBE;
                    end else if (Frame) begin
                        // Misplaced marker: restart the word on this bit.
                        ferr_d   = 1'b1;
                        shift_d  = (WORD_W-1)'(InputL);
                        bitcnt_d = BC_ONE;
                    end else begin
                        shift_d  = {shift_q[WORD_W-3:0], InputL};
                        bitcnt_d = bitcnt_q + BC_ONE;
                        if (bitcnt_q == BC_LAST) begin
                            word_d = {shift_q, InputL};
                            row_d  = cnt_q;
                        end
                    end
                end

                STROBE: begin
                    bitcnt_d = '0;
                    if (cnt_q == CNT_LAST) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        // A marker during the strobe opens the next word at once.
                        if (Frame) begin
                            shift_d  = (WORD_W-1)'(InputL);
                            bitcnt_d = BC_ONE;
                            state_d  = SHIFT;
                        end else begin
                            state_d = WAIT_FRAME;
                        end
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // Registered so the strobe is a clean flop output.
        strobe_d = (state_d == STROBE);
    end

    assign rj_status = strobe_q;
    assign row       = row_q;
    assign Input     = word_q;
    assign clear_mem = clr_q;
    assign rj_busy   = busy_q;
    assign rj_done   = done_q;
    assign frame_err = ferr_q;

endmodule

// File: tb/tb_rj_loader_l.sv
module tb_rj_loader_l;

    localparam int WORD_W = 16;
    localparam int DEPTH  = 16;
    localparam int ROW_W  = 4;

    logic              Sclk;
    logic              Reset_n;
    logic              Start;
    logic              Clear;
    logic              Frame;
    logic              InputL;
    logic              rj_status;
    logic [ROW_W-1:0]  row;
    logic [WORD_W-1:0] Input;
    logic              clear_mem;
    logic              rj_busy;
    logic              rj_done;
    logic              frame_err;

    rj_loader_l #(.WORD_W(WORD_W), .DEPTH(DEPTH), .ROW_W(ROW_W)) dut (
        .Sclk      (Sclk),
        .Reset_n   (Reset_n),
        .Start     (Start),
        .Clear     (Clear),
        .Frame     (Frame),
        .InputL    (InputL),
        .rj_status (rj_status),
        .row       (row),
        .Input     (Input),
        .clear_mem (clear_mem),
        .rj_busy   (rj_busy),
        .rj_done   (rj_done),
        .frame_err (frame_err)
    );

    initial Sclk = 1'b0;
    always #5 Sclk = ~Sclk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [ROW_W-1:0]  row;
        logic [WORD_W-1:0] word;
        logic              clr;
        int                gap;   // expected cycles since previous strobe, 0 = unchecked
    } exp_t;

    exp_t sbq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push(input logic [ROW_W-1:0] r, input logic [WORD_W-1:0] w,
                        input logic c, input int g);
        exp_t e;
        e.row  = r;
        e.word = w;
        e.clr  = c;
        e.gap  = g;
        sbq.push_back(e);
    endtask

    task automatic tick();
        @(posedge Sclk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Drives the first nbits bits of w, MSB first, Frame on the MSB.
    task automatic send_bits(input logic [WORD_W-1:0] w, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            Frame  = (i == 0);
            InputL = w[WORD_W-1-i];
            tick();
        end
        Frame  = 1'b0;
        InputL = 1'b0;
    endtask

    task automatic send_word(input logic [WORD_W-1:0] w);
        send_bits(w, WORD_W);
    endtask

    task automatic pulse_start();
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        idle(2);
        Reset_n = 1'b1;
        idle(1);
    endtask

    // Monitor: compares every strobe against the scoreboard head.
    int                cyc = 0;
    int                last_strobe = 0;
    logic              prev_st = 1'b0;
    logic [WORD_W-1:0] prev_in = '0;
    logic [ROW_W-1:0]  prev_row = '0;
    logic              after = 1'b0;
    logic [WORD_W-1:0] held_in = '0;
    logic [ROW_W-1:0]  held_row = '0;

    always @(negedge Sclk) begin
        exp_t e;
        cyc++;
        if (after) begin
            chk("strobe_width", {31'd0, rj_status}, 32'd0);
            chk("input_hold",   {16'd0, Input},     {16'd0, held_in});
            chk("row_hold",     {28'd0, row},       {28'd0, held_row});
            after = 1'b0;
        end
        if (rj_status && !prev_st) begin
            if (sbq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_strobe: row 0x%0h Input 0x%0h, expected no strobe (t=%0t)",
                         row, Input, $time);
            end else begin
                e = sbq.pop_front();
                chk("input_pre",  {16'd0, prev_in},  {16'd0, e.word});
                chk("row_pre",    {28'd0, prev_row}, {28'd0, e.row});
                chk("input",      {16'd0, Input},    {16'd0, e.word});
                chk("row",        {28'd0, row},      {28'd0, e.row});
                chk("clear_mem",  {31'd0, clear_mem}, {31'd0, e.clr});
                if (e.gap != 0) chk("strobe_gap", cyc - last_strobe, e.gap);
            end
            last_strobe = cyc;
            after       = 1'b1;
            held_in     = Input;
            held_row    = row;
        end
        prev_st  = rj_status;
        prev_in  = Input;
        prev_row = row;
    end

    task automatic chk_outs(input string nm, input logic st, input logic cm,
                            input logic bz, input logic dn, input logic fe);
        chk({nm, "_status"},    {31'd0, rj_status}, {31'd0, st});
        chk({nm, "_clear_mem"}, {31'd0, clear_mem}, {31'd0, cm});
        chk({nm, "_busy"},      {31'd0, rj_busy},   {31'd0, bz});
        chk({nm, "_done"},      {31'd0, rj_done},   {31'd0, dn});
        chk({nm, "_frame_err"}, {31'd0, frame_err}, {31'd0, fe});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset_n = 1'b0;
        Start   = 1'b0;
        Clear   = 1'b0;
        Frame   = 1'b0;
        InputL  = 1'b0;
        idle(3);
        // Reset state
        chk_outs("rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_row",   {28'd0, row},   32'd0);
        chk("rst_input", {16'd0, Input}, 32'd0);
        Reset_n = 1'b1;
        idle(2);

        // Sixteen spaced words 0x0001..0x0010 into rows 0..15
        pulse_start();
        chk("start_busy", {31'd0, rj_busy}, 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            push(ROW_W'(i), WORD_W'(i + 1), 1'b0, 0);
            send_word(WORD_W'(i + 1));
            idle(3);
        end
        chk_outs("done1", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Back-to-back words, Frame in the strobe cycle, restart from DONE
        pulse_start();
        chk_outs("start2", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            push(ROW_W'(i), 16'hC000 + WORD_W'(i * 3), 1'b0, (i == 0) ? 0 : 17);
            send_word(16'hC000 + WORD_W'(i * 3));
            idle(1);
        end
        idle(2);
        chk_outs("done2", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // 0xA5C3, then a misplaced Frame inside word 2
        pulse_start();
        push(4'd0, 16'hA5C3, 1'b0, 0);
        send_word(16'hA5C3);
        idle(3);
        push(4'd1, 16'h1111, 1'b0, 0);
        send_word(16'h1111);
        idle(3);
        chk("ferr_clean", {31'd0, frame_err}, 32'd0);
        push(4'd2, 16'h5A5A, 1'b0, 0);
        send_bits(16'hFFFF, 8);
        send_word(16'h5A5A);
        chk("ferr_set", {31'd0, frame_err}, 32'd1);
        idle(3);
        push(4'd3, 16'h7E81, 1'b0, 0);
        send_word(16'h7E81);
        idle(3);
        chk("ferr_sticky", {31'd0, frame_err}, 32'd1);
        Clear = 1'b1;
        tick();
        Clear = 1'b0;
        chk_outs("clr_a", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Clear in the middle of word 5
        do_reset();
        chk("rst_clear_mem", {31'd0, clear_mem}, 32'd0);
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            push(ROW_W'(i), 16'h0F00 + WORD_W'(i), 1'b0, 0);
            send_word(16'h0F00 + WORD_W'(i));
            idle(3);
        end
        send_bits(16'hBEEF, 8);
        Clear = 1'b1;
        tick();
        Clear = 1'b0;
        chk_outs("clr_b", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(20);
        pulse_start();
        push(4'd0, 16'h1234, 1'b1, 0);
        send_word(16'h1234);
        idle(1);
        chk("clr_at_strobe_st", {31'd0, rj_status}, 32'd1);
        chk("clr_at_strobe",    {31'd0, clear_mem}, 32'd1);
        idle(1);
        chk("clr_after_strobe", {31'd0, clear_mem}, 32'd0);
        idle(2);
        push(4'd1, 16'h4321, 1'b0, 0);
        send_word(16'h4321);
        idle(3);

        // Asynchronous reset during word 9
        do_reset();
        pulse_start();
        for (int i = 0; i < 9; i++) begin
            push(ROW_W'(i), 16'h9000 + WORD_W'(i), 1'b0, 0);
            send_word(16'h9000 + WORD_W'(i));
            idle(3);
        end
        send_bits(16'hFFFF, 5);
        #2;
        Reset_n = 1'b0;
        #1;
        chk_outs("async_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("async_rst_row",   {28'd0, row},   32'd0);
        chk("async_rst_input", {16'd0, Input}, 32'd0);
        idle(2);
        Reset_n = 1'b1;
        idle(2);

        // Start while busy is ignored; Start together with Clear goes to IDLE
        pulse_start();
        push(4'd0, 16'h0A0A, 1'b0, 0);
        send_word(16'h0A0A);
        idle(3);
        push(4'd1, 16'h0B0B, 1'b0, 0);
        send_word(16'h0B0B);
        idle(3);
        pulse_start();
        chk_outs("busy_start", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        push(4'd2, 16'h0C0C, 1'b0, 0);
        send_word(16'h0C0C);
        idle(3);
        Start = 1'b1;
        Clear = 1'b1;
        tick();
        Start = 1'b0;
        Clear = 1'b0;
        chk_outs("start_clear", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);
        chk("start_clear_idle", {31'd0, rj_busy}, 32'd0);
        send_word(16'hDEAD);
        idle(5);

        chk("sb_empty", sbq.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
